// File: rtl/maze_player_ctrl.sv
// Player movement controller: debounces four direction buttons, checks each move
// against the maze wall bitmaps, and hands new cell coordinates to the sprite renderer.
module maze_player_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CELL_SIZE       = 20,
  parameter int unsigned X_ORIGIN        = 20,
  parameter int unsigned Y_ORIGIN        = 10,
  parameter int unsigned START_COL       = 0,
  parameter int unsigned START_ROW       = 0,
  parameter int unsigned GOAL_COL        = 9,
  parameter int unsigned GOAL_ROW        = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic [159:0] h_walls,
  input  logic [164:0] v_walls,
  output logic [3:0]   col,
  output logic [3:0]   row,
  output logic [8:0]   x,
  output logic [8:0]   y,
  output logic [8:0]   prev_x,
  output logic [8:0]   prev_y,
  output logic         pos_valid,
  input  logic         pos_ready,
  output logic         blocked,
  output logic         win
);

  localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0]         X0       = 9'(X_ORIGIN);
  localparam logic [8:0]         Y0       = 9'(Y_ORIGIN);
  localparam logic [8:0]         CELL     = 9'(CELL_SIZE);
  localparam logic [8:0]         START_X  = 9'(X_ORIGIN + START_COL * CELL_SIZE);
  localparam logic [8:0]         START_Y  = 9'(Y_ORIGIN + START_ROW * CELL_SIZE);

  typedef enum logic [1:0] {IDLE, CHECK, MOVE, NOTIFY} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  // Button vector order: [3]=up [2]=down [1]=left [0]=right
  logic [3:0]       btn_raw;
  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]       db_q, db_d, db_prev_q, db_prev_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i] = ~db_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic [8:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic       pos_valid_q, pos_valid_d, win_q, win_d;

  logic [7:0] row_ext, col_ext;
  logic [7:0] h_up_idx, h_dn_idx, v_lf_idx, v_rt_idx;
  logic [3:0] tgt_col, tgt_row;
  logic       legal, ack;

  // Flattened wall indices; row/line 0 and column/segment 0 sit at the MSB end.
  assign row_ext  = {4'd0, row_q};
  assign col_ext  = {4'd0, col_q};
  assign h_up_idx = 8'd159 - row_ext * 8'd10 - col_ext;
  assign h_dn_idx = 8'd149 - row_ext * 8'd10 - col_ext;
  assign v_lf_idx = 8'd164 - row_ext * 8'd11 - col_ext;
  assign v_rt_idx = 8'd163 - row_ext * 8'd11 - col_ext;

  always_comb begin
    tgt_col = col_q;
    tgt_row = row_q;
    legal   = 1'b0;
    case (dir_q)
      DIR_UP: begin
        tgt_row = row_q - 4'd1;
        legal   = (row_q != 4'd0) && !h_walls[h_up_idx];
      end
      DIR_DOWN: begin
        tgt_row = row_q + 4'd1;
        legal   = (row_q != 4'd14) && !h_walls[h_dn_idx];
      end
      DIR_LEFT: begin
        tgt_col = col_q - 4'd1;
        legal   = (col_q != 4'd0) && !v_walls[v_lf_idx];
      end
      default: begin
        tgt_col = col_q + 4'd1;
        legal   = (col_q != 4'd9) && !v_walls[v_rt_idx];
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    col_d       = col_q;
    row_d       = row_q;
    x_d         = x_q;
    y_d         = y_q;
    px_d        = px_q;
    py_d        = py_q;
    pos_valid_d = pos_valid_q;
    win_d       = win_q;
    blocked     = 1'b0;
    ack         = pos_valid_q && pos_ready;
    if (ack) pos_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !pos_valid_q && (|press)) begin
          state_d = CHECK;
          if      (press[3]) dir_d = DIR_UP;
          else if (press[2]) dir_d = DIR_DOWN;
          else if (press[1]) dir_d = DIR_LEFT;
          else               dir_d = DIR_RIGHT;
        end
      end
      CHECK: begin
        // Position registers load on the CHECK->MOVE edge so the new cell,
        // pos_valid and win are all visible during the MOVE cycle.
        if (legal) begin
          col_d       = tgt_col;
          row_d       = tgt_row;
          px_d        = x_q;
          py_d        = y_q;
          x_d         = X0 + {5'd0, tgt_col} * CELL;
          y_d         = Y0 + {5'd0, tgt_row} * CELL;
          pos_valid_d = 1'b1;
          if (tgt_col == 4'(GOAL_COL) && tgt_row == 4'(GOAL_ROW)) win_d = 1'b1;
          state_d     = MOVE;
        end else begin
          blocked = 1'b1;
          state_d = IDLE;
        end
      end
      MOVE:    state_d = ack ? IDLE : NOTIFY;
      NOTIFY:  if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      dir_q       <= DIR_UP;
      col_q       <= 4'(START_COL);
      row_q       <= 4'(START_ROW);
      x_q         <= START_X;
      y_q         <= START_Y;
      px_q        <= START_X;
      py_q        <= START_Y;
      pos_valid_q <= 1'b1;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      col_q       <= col_d;
      row_q       <= row_d;
      x_q         <= x_d;
      y_q         <= y_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pos_valid_q <= pos_valid_d;
      win_q       <= win_d;
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign x         = x_q;
  assign y         = y_q;
  assign prev_x    = px_q;
  assign prev_y    = py_q;
  assign pos_valid = pos_valid_q;
  assign win       = win_q;

endmodule
